// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding, default widths and flag payload for the ALU execute stage.
package alu_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_SHW   = 5;
    localparam int unsigned OPW       = 4;

    localparam logic [OPW-1:0] OP_ADD  = 4'd0;
    localparam logic [OPW-1:0] OP_SUB  = 4'd1;
    localparam logic [OPW-1:0] OP_AND  = 4'd2;
    localparam logic [OPW-1:0] OP_OR   = 4'd3;
    localparam logic [OPW-1:0] OP_XOR  = 4'd4;
    localparam logic [OPW-1:0] OP_NOR  = 4'd5;
    localparam logic [OPW-1:0] OP_SLT  = 4'd6;
    localparam logic [OPW-1:0] OP_SLTU = 4'd7;
    localparam logic [OPW-1:0] OP_SLL  = 4'd8;
    localparam logic [OPW-1:0] OP_SRL  = 4'd9;
    localparam logic [OPW-1:0] OP_SRA  = 4'd10;
    localparam logic [OPW-1:0] OP_MUL  = 4'd11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    typedef struct packed {
        logic zero;
        logic carry;
        logic ovf;
        logic illegal;
    } alu_flags_t;

endpackage

// File: rtl/alu_exec_stage_if.sv
// Operand/opcode request and result response bundle between decode, the ALU and write-back.
interface alu_exec_stage_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [OPW-1:0]   opcode;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             ovf;
    logic             illegal;

    modport master (
        output in_valid, opcode, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, carry, ovf, illegal
    );

    modport slave (
        input  in_valid, opcode, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, carry, ovf, illegal
    );
endinterface

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one partial product per clock, low WIDTH bits of the product.
module alu_seq_mul
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SHW   = DEF_SHW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_product
);
    localparam int unsigned   CW   = SHW + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplr;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_count;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] w_acc_nxt;

    assign w_acc_nxt = r_acc + (r_mplr[0] ? r_mcand : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand <= '0;
            r_mplr  <= '0;
            r_acc   <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_mcand <= i_a;
                r_mplr  <= i_b;
                r_acc   <= '0;
                r_count <= '0;
                r_busy  <= 1'b1;
            end else if (r_busy) begin
                r_acc   <= w_acc_nxt;
                r_mcand <= r_mcand << 1;
                r_mplr  <= r_mplr >> 1;
                r_count <= r_count + CW'(1);
                // final iteration: accumulator now holds the product
                if (r_count == LAST) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_product = r_acc;

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: single-cycle ALU ops plus iterative MUL behind a valid/ready handshake with a held output register.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SHW   = DEF_SHW
) (
    input  logic            clk,
    input  logic            rst,
    alu_exec_stage_if.slave io_bus
);
    state_e           r_state;
    state_e           w_state_nxt;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_is_mul;
    logic             w_mul_start;
    logic             w_mul_busy;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_product;
    alu_flags_t       w_mul_flags;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_res;
    alu_flags_t       w_flags;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    alu_flags_t       r_flags;

    assign w_a      = io_bus.op_a;
    assign w_b      = io_bus.op_b;
    assign w_shamt  = w_b[SHW-1:0];
    assign w_sum    = {1'b0, w_a} + {1'b0, w_b};
    assign w_diff   = {1'b0, w_a} - {1'b0, w_b};
    assign w_is_mul = (io_bus.opcode == OP_MUL);
    assign w_accept = io_bus.in_valid && w_in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_mul_start) w_state_nxt = ST_MUL;
            ST_MUL:  if (w_mul_done)  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // accept only when idle and the output slot is free or being drained this cycle
    always_comb begin
        w_in_ready  = 1'b0;
        w_mul_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready  = !w_mul_busy && (!r_out_valid || io_bus.out_ready);
                w_mul_start = w_in_ready && io_bus.in_valid && w_is_mul;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_res   = '0;
        w_flags = '0;
        case (io_bus.opcode)
            OP_ADD: begin
                w_res         = w_sum[WIDTH-1:0];
                w_flags.carry = w_sum[WIDTH];
                w_flags.ovf   = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res         = w_diff[WIDTH-1:0];
                w_flags.carry = w_diff[WIDTH];
                w_flags.ovf   = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);
            end
            OP_AND:  w_res = w_a & w_b;
            OP_OR:   w_res = w_a | w_b;
            OP_XOR:  w_res = w_a ^ w_b;
            OP_NOR:  w_res = ~(w_a | w_b);
            OP_SLT:  w_res = WIDTH'($signed(w_a) < $signed(w_b));
            OP_SLTU: w_res = WIDTH'(w_a < w_b);
            OP_SLL:  w_res = w_a << w_shamt;
            OP_SRL:  w_res = w_a >> w_shamt;
            OP_SRA:  w_res = WIDTH'($signed(w_a) >>> w_shamt);
            OP_MUL:  ;
            default: w_flags.illegal = 1'b1;
        endcase
        w_flags.zero = (w_res == '0);
    end

    always_comb begin
        w_mul_flags      = '0;
        w_mul_flags.zero = (w_mul_product == '0);
    end

    alu_seq_mul #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_mul_start),
        .i_a       (w_a),
        .i_b       (w_b),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_product (w_mul_product)
    );

    // result register: load on completion, otherwise hold until popped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
        end else if (w_accept && !w_is_mul) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_flags     <= w_flags;
        end else if (w_mul_done) begin
            r_out_valid <= 1'b1;
            r_result    <= w_mul_product;
            r_flags     <= w_mul_flags;
        end else if (r_out_valid && io_bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign io_bus.in_ready  = w_in_ready;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.result    = r_result;
    assign io_bus.zero      = r_flags.zero;
    assign io_bus.carry     = r_flags.carry;
    assign io_bus.ovf       = r_flags.ovf;
    assign io_bus.illegal   = r_flags.illegal;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed plus random bench for alu_exec_stage with a result scoreboard and per-cycle handshake checks.
module tb_alu_exec_stage;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        v;
        logic        i;
    } exp_t;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;
    exp_t sb[$];

    alu_exec_stage_if #(.WIDTH(32)) bus ();

    alu_exec_stage dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [32:0] w;
        e = '0;
        case (op)
            4'd0: begin
                w = {1'b0, a} + {1'b0, b};
                e.res = w[31:0];
                e.c = w[32];
                e.v = (a[31] == b[31]) && (e.res[31] != a[31]);
            end
            4'd1: begin
                e.res = a - b;
                e.c = (a < b);
                e.v = (a[31] != b[31]) && (e.res[31] != a[31]);
            end
            4'd2:  e.res = a & b;
            4'd3:  e.res = a | b;
            4'd4:  e.res = a ^ b;
            4'd5:  e.res = ~(a | b);
            4'd6:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:  e.res = (a < b) ? 32'd1 : 32'd0;
            4'd8:  e.res = a << b[4:0];
            4'd9:  e.res = a >> b[4:0];
            4'd10: e.res = 32'($signed(a) >>> b[4:0]);
            4'd11: e.res = a * b;
            default: e.i = 1'b1;
        endcase
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    function automatic exp_t obs_bundle();
        return {bus.result, bus.zero, bus.carry, bus.ovf, bus.illegal};
    endfunction

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.op_a     = a;
        bus.op_b     = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (ok) sb.push_back(model(op, a, b));
        chk("accept", 64'(ok), 64'd1);
    endtask

    task automatic wait_valid(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, 64'(seen), 64'd1);
    endtask

    // scoreboard: every handshaked result is compared against the oldest expectation
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", 64'(obs_bundle()), 64'h0);
                chk("sb_empty", 64'd1, 64'd0);
            end else begin
                chk("sb_result", 64'(obs_bundle()), 64'(sb.pop_front()));
            end
        end
    end

    initial begin
        exp_t e;
        n_chk = 0;
        n_err = 0;
        clk = 1'b0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.opcode    = 4'd0;
        bus.op_a      = 32'd0;
        bus.op_b      = 32'd0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_bundle", 64'(obs_bundle()), 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        send(4'd0, 32'h7FFF_FFFF, 32'h1);
        chk("add_latency", 64'(bus.out_valid), 64'd1);
        chk("add_ovf", 64'(obs_bundle()), 64'({32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0}));

        send(4'd1, 32'd5, 32'd5);
        chk("sub0_valid", 64'(bus.out_valid), 64'd1);
        chk("sub0_zero", 64'(obs_bundle()), 64'({32'h0, 1'b1, 1'b0, 1'b0, 1'b0}));
        send(4'd1, 32'd3, 32'd4);
        chk("sub1_valid", 64'(bus.out_valid), 64'd1);
        chk("sub1_borrow", 64'(obs_bundle()), 64'({32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0}));

        send(4'd10, 32'h8000_0000, 32'h0000_0024);
        chk("sra", 64'(obs_bundle()), 64'({32'hF800_0000, 4'b0000}));
        send(4'd6, 32'hFFFF_FFFF, 32'd1);
        chk("slt", 64'(obs_bundle()), 64'({32'd1, 4'b0000}));
        send(4'd7, 32'hFFFF_FFFF, 32'd1);
        chk("sltu", 64'(obs_bundle()), 64'({32'd0, 4'b1000}));

        send(4'd11, 32'd12, 32'd13);
        for (int i = 1; i <= 32; i++) begin
            @(posedge clk);
            #1;
            chk("mul_busy_in_ready", 64'(bus.in_ready), 64'd0);
            chk("mul_busy_out_valid", 64'(bus.out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        chk("mul_latency", 64'(bus.out_valid), 64'd1);
        chk("mul_12x13", 64'(obs_bundle()), 64'({32'd156, 4'b0000}));

        send(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_valid("mul2_done");
        chk("mul_ffxff", 64'(obs_bundle()), 64'({32'd1, 4'b0000}));
        @(posedge clk);
        #1;

        bus.out_ready = 1'b0;
        send(4'd2, 32'h0000_F0F0, 32'h0000_FF00);
        bus.in_valid = 1'b1;
        bus.opcode   = 4'd4;
        bus.op_a     = 32'd1;
        bus.op_b     = 32'd2;
        sb.push_back(model(4'd4, 32'd1, 32'd2));
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_bundle", 64'(obs_bundle()), 64'({32'h0000_F000, 4'b0000}));
            chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("pop_accept_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("pop_accept_valid", 64'(bus.out_valid), 64'd1);
        chk("pop_accept_xor", 64'(obs_bundle()), 64'({32'd3, 4'b0000}));
        @(posedge clk);
        #1;

        send(4'd11, 32'd7, 32'd9);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_bundle", 64'(obs_bundle()), 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
        repeat (35) @(posedge clk);
        #1;
        chk("abort_no_result", 64'(bus.out_valid), 64'd0);

        send(4'd14, 32'h1234_5678, 32'h9ABC_DEF0);
        chk("illegal", 64'(obs_bundle()), 64'({32'd0, 1'b1, 1'b0, 1'b0, 1'b1}));
        @(posedge clk);
        #1;
        chk("pop_clears_valid", 64'(bus.out_valid), 64'd0);

        for (int k = 0; k < 24; k++) begin
            send(4'($urandom_range(0, 15)), $urandom, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk("sb_drain", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
